// File: rtl/pe_reducer_sched.sv
// pe_reducer_sched: packs sparse nonzero entries into groups of three,
// launches one reducer op per group and holds operands until it finishes.
module pe_reducer_sched #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_job_start,
  input  logic [LEN_W-1:0] i_job_len,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timeout,
  output logic [LEN_W-1:0] o_group_cnt,
  input  logic             i_ent_valid,
  output logic             o_ent_ready,
  input  logic [20:0]      i_ent_addr,
  input  logic [15:0]      i_ent_w,
  input  logic [15:0]      i_ent_ia,
  output logic             o_pe_start,
  output logic [20:0]      o_pe_addr [0:2],
  output logic [15:0]      o_pe_w    [0:2],
  output logic [15:0]      o_pe_ia   [0:2],
  input  logic             i_pe_finish
);

  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GATHER = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e           state_q;
  logic [LEN_W-1:0] rem_q;
  logic [1:0]       idx_q;
  logic [WC_W-1:0]  wcnt_q;
  logic [20:0]      slot_addr_q [0:2];
  logic [15:0]      slot_w_q    [0:2];
  logic [15:0]      slot_ia_q   [0:2];

  logic       accept;
  logic       gather_done;
  logic [1:0] last_idx;

  assign o_busy      = (state_q != S_IDLE);
  assign o_ent_ready = (state_q == S_GATHER)
                     && (idx_q != 2'd3)
                     && (rem_q != '0);
  assign accept      = o_ent_ready & i_ent_valid;
  assign gather_done = (idx_q == 2'd3) || (rem_q == '0);
  assign last_idx    = idx_q - 2'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      idx_q       <= '0;
      wcnt_q      <= '0;
      o_done      <= 1'b0;
      o_timeout   <= 1'b0;
      o_group_cnt <= '0;
      o_pe_start  <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        slot_addr_q[k] <= '0;
        slot_w_q[k]    <= '0;
        slot_ia_q[k]   <= '0;
        o_pe_addr[k]   <= '0;
        o_pe_w[k]      <= '0;
        o_pe_ia[k]     <= '0;
      end
    end else begin
      o_done     <= 1'b0;
      o_pe_start <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (i_job_start) begin
            rem_q       <= i_job_len;
            idx_q       <= '0;
            o_group_cnt <= '0;
            o_timeout   <= 1'b0;
            if (i_job_len == '0) begin
              state_q <= S_DONE;
              o_done  <= 1'b1;
            end else begin
              state_q <= S_GATHER;
            end
          end
        end
        S_GATHER: begin
          if (gather_done) begin
            // short tail: pad with the last real address and zero data
            for (int k = 0; k < 3; k++) begin
              if (2'(k) < idx_q) begin
                o_pe_addr[k] <= slot_addr_q[k];
                o_pe_w[k]    <= slot_w_q[k];
                o_pe_ia[k]   <= slot_ia_q[k];
              end else begin
                o_pe_addr[k] <= slot_addr_q[last_idx];
                o_pe_w[k]    <= '0;
                o_pe_ia[k]   <= '0;
              end
            end
            o_pe_start <= 1'b1;
            state_q    <= S_ISSUE;
          end else if (accept) begin
            slot_addr_q[idx_q] <= i_ent_addr;
            slot_w_q[idx_q]    <= i_ent_w;
            slot_ia_q[idx_q]   <= i_ent_ia;
            idx_q              <= idx_q + 2'd1;
            rem_q              <= rem_q - LEN_W'(1);
          end
        end
        S_ISSUE: begin
          o_group_cnt <= o_group_cnt + LEN_W'(1);
          wcnt_q      <= '0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          if (i_pe_finish) begin
            if (rem_q == '0) begin
              state_q <= S_DONE;
              o_done  <= 1'b1;
            end else begin
              idx_q   <= '0;
              state_q <= S_GATHER;
            end
          end else if (wcnt_q == WC_LAST) begin
            o_timeout <= 1'b1;
            o_done    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            wcnt_q <= wcnt_q + WC_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_reducer_sched.sv
// tb_pe_reducer_sched: directed scenarios for the PE reducer sequencer.
// Each task drives one scenario and checks hand-computed results inline.
module tb_pe_reducer_sched;

  localparam int TIMEOUT = 15;

  logic        clk;
  logic        rst_n;
  logic        job_start;
  logic [15:0] job_len;
  logic        busy;
  logic        done;
  logic        tmo;
  logic [15:0] gcnt;
  logic        ent_valid;
  logic        ready;
  logic [20:0] ent_addr;
  logic [15:0] ent_w;
  logic [15:0] ent_ia;
  logic        pe_start;
  logic [20:0] pe_addr [0:2];
  logic [15:0] pe_w    [0:2];
  logic [15:0] pe_ia   [0:2];
  logic        pe_finish;

  pe_reducer_sched #(.LEN_W(16), .TIMEOUT(TIMEOUT)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_job_start (job_start),
    .i_job_len   (job_len),
    .o_busy      (busy),
    .o_done      (done),
    .o_timeout   (tmo),
    .o_group_cnt (gcnt),
    .i_ent_valid (ent_valid),
    .o_ent_ready (ready),
    .i_ent_addr  (ent_addr),
    .i_ent_w     (ent_w),
    .i_ent_ia    (ent_ia),
    .o_pe_start  (pe_start),
    .o_pe_addr   (pe_addr),
    .o_pe_w      (pe_w),
    .o_pe_ia     (pe_ia),
    .i_pe_finish (pe_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [20:0] e_addr [16];
  logic [15:0] e_w    [16];
  logic [15:0] e_ia   [16];

  logic [20:0] cap_a  [4][3];
  logic [15:0] cap_w  [4][3];
  logic [15:0] cap_ia [4][3];

  int r_starts, r_dones, r_acc, r_unstable;
  int r_ready_cyc, r_st2done, r_edges;

  // Runs one job at negedge granularity and records what it observed.
  task automatic run_job(input int len, input bit toggle,
                         input int fin_dly, input int budget);
    int  ei;
    int  since;
    bit  fire;
    bit  tog;
    bit  waiting;
    int  g;
    r_starts = 0; r_dones = 0; r_acc = 0; r_unstable = 0;
    r_ready_cyc = 0; r_st2done = -1; r_edges = -1;
    ei = 0; since = -1; tog = 1'b1; waiting = 1'b0;
    @(negedge clk);
    job_start = 1'b1;
    job_len   = 16'(len);
    ent_valid = (len > 0);
    ent_addr  = e_addr[0];
    ent_w     = e_w[0];
    ent_ia    = e_ia[0];
    for (int c = 0; c < budget; c++) begin
      fire = ent_valid && ready;
      @(negedge clk);
      job_start = 1'b0;
      pe_finish = 1'b0;
      if (fire) begin
        r_acc++;
        ei++;
      end
      if (ready) r_ready_cyc++;
      if (since >= 0) since++;
      if (pe_start) begin
        r_starts++;
        since   = 0;
        waiting = 1'b1;
        if (r_starts <= 4) begin
          for (int k = 0; k < 3; k++) begin
            cap_a[r_starts-1][k]  = pe_addr[k];
            cap_w[r_starts-1][k]  = pe_w[k];
            cap_ia[r_starts-1][k] = pe_ia[k];
          end
        end
      end else if (waiting && r_starts >= 1 && r_starts <= 4) begin
        g = r_starts - 1;
        for (int k = 0; k < 3; k++) begin
          if (pe_addr[k] !== cap_a[g][k] || pe_w[k] !== cap_w[g][k]
              || pe_ia[k] !== cap_ia[g][k])
            r_unstable++;
        end
      end
      if (done) begin
        r_dones++;
        r_st2done = since;
        r_edges   = c + 1;
        break;
      end
      if (waiting && fin_dly >= 0 && since == fin_dly) begin
        pe_finish = 1'b1;
        waiting   = 1'b0;
      end
      if (toggle) tog = !tog;
      ent_valid = (ei < len) && tog;
      ent_addr  = e_addr[ei & 15];
      ent_w     = e_w[ei & 15];
      ent_ia    = e_ia[ei & 15];
    end
    job_start = 1'b0;
    ent_valid = 1'b0;
    pe_finish = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, tmo, ready, pe_start} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 00000",
               {busy, done, tmo, ready, pe_start});
    end
    n_cmp++;
    if (gcnt !== 16'd0 || pe_addr[2] !== 21'd0 || pe_w[0] !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_regs: got gcnt=%0d addr2=%h w0=%h want 0",
               gcnt, pe_addr[2], pe_w[0]);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_len3();
    run_job(3, 1'b0, 2, 100);
    n_cmp++;
    if (r_starts !== 1 || r_dones !== 1) begin
      n_bad++;
      $display("FAIL len3_counts: got starts=%0d dones=%0d want 1 1",
               r_starts, r_dones);
    end
    n_cmp++;
    if (cap_w[0][0] !== 16'd1 || cap_w[0][1] !== 16'd2
        || cap_w[0][2] !== 16'd3) begin
      n_bad++;
      $display("FAIL len3_w: got %0d %0d %0d want 1 2 3",
               cap_w[0][0], cap_w[0][1], cap_w[0][2]);
    end
    n_cmp++;
    if (cap_a[0][0] !== e_addr[0] || cap_a[0][2] !== e_addr[2]
        || cap_ia[0][1] !== e_ia[1]) begin
      n_bad++;
      $display("FAIL len3_addr: got %h %h ia1=%h want %h %h %h",
               cap_a[0][0], cap_a[0][2], cap_ia[0][1],
               e_addr[0], e_addr[2], e_ia[1]);
    end
    n_cmp++;
    if (gcnt !== 16'd1 || r_acc !== 3) begin
      n_bad++;
      $display("FAIL len3_gcnt: got gcnt=%0d acc=%0d want 1 3", gcnt, r_acc);
    end
    n_cmp++;
    if (r_st2done !== 3) begin
      n_bad++;
      $display("FAIL len3_latency: got %0d want 3", r_st2done);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL len3_idle: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_len7();
    run_job(7, 1'b0, 2, 200);
    n_cmp++;
    if (r_starts !== 3 || r_dones !== 1 || gcnt !== 16'd3) begin
      n_bad++;
      $display("FAIL len7_counts: got starts=%0d dones=%0d gcnt=%0d want 3 1 3",
               r_starts, r_dones, gcnt);
    end
    n_cmp++;
    if (cap_w[1][0] !== 16'd4 || cap_w[1][2] !== 16'd6) begin
      n_bad++;
      $display("FAIL len7_g1: got %0d %0d want 4 6", cap_w[1][0], cap_w[1][2]);
    end
    n_cmp++;
    if (cap_a[2][0] !== e_addr[6] || cap_a[2][1] !== e_addr[6]
        || cap_a[2][2] !== e_addr[6]) begin
      n_bad++;
      $display("FAIL len7_pad_addr: got %h %h %h want %h",
               cap_a[2][0], cap_a[2][1], cap_a[2][2], e_addr[6]);
    end
    n_cmp++;
    if (cap_w[2][0] !== 16'd7 || cap_w[2][1] !== 16'd0 || cap_w[2][2] !== 16'd0
        || cap_ia[2][0] !== e_ia[6] || cap_ia[2][1] !== 16'd0
        || cap_ia[2][2] !== 16'd0) begin
      n_bad++;
      $display("FAIL len7_pad_data: got w=%0d %0d %0d ia=%h %h %h want 7 0 0 %h 0 0",
               cap_w[2][0], cap_w[2][1], cap_w[2][2],
               cap_ia[2][0], cap_ia[2][1], cap_ia[2][2], e_ia[6]);
    end
  endtask

  task automatic test_len0();
    run_job(0, 1'b0, 2, 20);
    n_cmp++;
    if (r_dones !== 1 || r_edges !== 1) begin
      n_bad++;
      $display("FAIL len0_done: got dones=%0d edges=%0d want 1 1",
               r_dones, r_edges);
    end
    n_cmp++;
    if (r_starts !== 0 || r_ready_cyc !== 0 || r_acc !== 0) begin
      n_bad++;
      $display("FAIL len0_quiet: got starts=%0d ready=%0d acc=%0d want 0",
               r_starts, r_ready_cyc, r_acc);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL len0_pulse: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_len4_toggle();
    run_job(4, 1'b1, 3, 200);
    n_cmp++;
    if (r_acc !== 4 || r_starts !== 2 || gcnt !== 16'd2 || r_dones !== 1) begin
      n_bad++;
      $display("FAIL len4_counts: got acc=%0d starts=%0d gcnt=%0d dones=%0d want 4 2 2 1",
               r_acc, r_starts, gcnt, r_dones);
    end
    n_cmp++;
    if (cap_w[0][0] !== 16'd1 || cap_w[0][1] !== 16'd2
        || cap_w[0][2] !== 16'd3) begin
      n_bad++;
      $display("FAIL len4_g0: got %0d %0d %0d want 1 2 3",
               cap_w[0][0], cap_w[0][1], cap_w[0][2]);
    end
    n_cmp++;
    if (cap_w[1][0] !== 16'd4 || cap_w[1][1] !== 16'd0
        || cap_a[1][2] !== e_addr[3]) begin
      n_bad++;
      $display("FAIL len4_g1: got w=%0d %0d a2=%h want 4 0 %h",
               cap_w[1][0], cap_w[1][1], cap_a[1][2], e_addr[3]);
    end
    n_cmp++;
    if (r_unstable !== 0) begin
      n_bad++;
      $display("FAIL len4_stable: got %0d changes want 0", r_unstable);
    end
  endtask

  task automatic test_timeout();
    run_job(3, 1'b0, -1, 100);
    n_cmp++;
    if (r_dones !== 1 || tmo !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_set: got dones=%0d tmo=%b want 1 1", r_dones, tmo);
    end
    n_cmp++;
    if (r_st2done !== TIMEOUT + 1) begin
      n_bad++;
      $display("FAIL tmo_latency: got %0d want %0d", r_st2done, TIMEOUT + 1);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (tmo !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_sticky: got tmo=%b busy=%b want 1 0", tmo, busy);
    end
    run_job(3, 1'b0, 2, 100);
    n_cmp++;
    if (tmo !== 1'b0 || r_dones !== 1 || gcnt !== 16'd1) begin
      n_bad++;
      $display("FAIL tmo_recover: got tmo=%b dones=%0d gcnt=%0d want 0 1 1",
               tmo, r_dones, gcnt);
    end
  endtask

  task automatic test_reset_in_wait();
    bit in_wait;
    in_wait = 1'b0;
    @(negedge clk);
    job_start = 1'b1;
    job_len   = 16'd3;
    ent_valid = 1'b1;
    ent_addr  = e_addr[0];
    ent_w     = e_w[0];
    ent_ia    = e_ia[0];
    @(negedge clk);
    job_start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (ready) begin
        @(negedge clk);
        ent_addr = e_addr[c + 1];
        ent_w    = e_w[c + 1];
        ent_ia   = e_ia[c + 1];
      end else begin
        ent_valid = 1'b0;
        @(negedge clk);
      end
      if (pe_start) begin
        @(negedge clk);
        in_wait = 1'b1;
        break;
      end
    end
    ent_valid = 1'b0;
    n_cmp++;
    if (!in_wait || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_reach_wait: got reached=%b busy=%b want 1 1",
               in_wait, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, tmo, ready, pe_start} !== 5'b0 || gcnt !== 16'd0
        || pe_w[0] !== 16'd0 || pe_addr[0] !== 21'd0) begin
      n_bad++;
      $display("FAIL rst_async: got flags=%b gcnt=%0d w0=%h a0=%h want 0",
               {busy, done, tmo, ready, pe_start}, gcnt, pe_w[0], pe_addr[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_job(3, 1'b0, 2, 100);
    n_cmp++;
    if (r_starts !== 1 || r_dones !== 1 || gcnt !== 16'd1
        || cap_w[0][2] !== 16'd3) begin
      n_bad++;
      $display("FAIL rst_fresh_job: got starts=%0d dones=%0d gcnt=%0d w2=%0d want 1 1 1 3",
               r_starts, r_dones, gcnt, cap_w[0][2]);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    job_start = 1'b0;
    job_len   = '0;
    ent_valid = 1'b0;
    ent_addr  = '0;
    ent_w     = '0;
    ent_ia    = '0;
    pe_finish = 1'b0;
    for (int i = 0; i < 16; i++) begin
      e_addr[i] = {7'(i + 1), 7'(2 * i + 3), 7'(i + 5)};
      e_w[i]    = 16'(i + 1);
      e_ia[i]   = 16'(16'hFFF0 + i);
    end
    test_reset();
    test_len3();
    test_len7();
    test_len0();
    test_len4_toggle();
    test_timeout();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
